debounce_scheduler: RTL and testbench

- Shares one debounce timer among N_CH noisy robot inputs (limit switches, bumper, pushbuttons).
- Synchronises each input and detects channels whose input differs from the stable value.
- Grants the timer to one channel at a time, round-robin, and commits the new stable value only after the input has held for HOLD_CYCLES.
- Sits between the raw sensor pins and the robot's motion FSM. Emits a one-cycle change event tagged with the channel number.

---
 rtl/debounce_scheduler.sv | 123 ++++++++++++
 tb/tb_debounce_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/debounce_scheduler.sv
// rtl/debounce_scheduler.sv - shared-timer debouncer for N_CH noisy inputs
// One hold counter is granted round-robin to channels whose synchronised input differs from the stable value.
module debounce_scheduler #(
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int CNT_W       = 20,
  parameter int HOLD_CYCLES = 1048575
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] noisy,
  input  logic            enable,
  output logic [N_CH-1:0] debounced,
  output logic            change_pulse,
  output logic [CH_W-1:0] change_ch,
  output logic            busy,
  output logic [CH_W-1:0] active_ch
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

  state_t          state, state_nxt;
  logic [N_CH-1:0] sync1, sync2, req, debounced_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CH_W-1:0] ptr, ptr_nxt, grant_ch, active_ch_nxt, change_ch_nxt, after_active;
  logic            grant_found, busy_nxt, pulse_nxt;

  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_CH) s = s - N_CH;
    return CH_W'(s);
  endfunction

  assign req          = sync2 ^ debounced;
  assign after_active = (active_ch == CH_LAST) ? '0 : active_ch + 1'b1;

  // First requesting channel at or after ptr, wrapping modulo N_CH.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!grant_found && req[rr_idx(ptr, i)]) begin
        grant_found = 1'b1;
        grant_ch    = rr_idx(ptr, i);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ptr_nxt       = ptr;
    active_ch_nxt = active_ch;
    busy_nxt      = busy;
    pulse_nxt     = 1'b0;
    change_ch_nxt = change_ch;
    debounced_nxt = debounced;
    case (state)
      IDLE: begin
        if (enable && grant_found) begin
          state_nxt     = COUNT;
          active_ch_nxt = grant_ch;
          cnt_nxt       = '0;
          busy_nxt      = 1'b1;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else if (sync2[active_ch] == debounced[active_ch]) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
          ptr_nxt   = after_active;
        end else if (cnt == CNT_LAST) begin
          debounced_nxt[active_ch] = sync2[active_ch];
          pulse_nxt     = 1'b1;
          change_ch_nxt = active_ch;
          state_nxt     = IDLE;
          busy_nxt      = 1'b0;
          cnt_nxt       = '0;
          ptr_nxt       = after_active;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      sync1        <= '0;
      sync2        <= '0;
      cnt          <= '0;
      ptr          <= '0;
      active_ch    <= '0;
      busy         <= 1'b0;
      change_pulse <= 1'b0;
      change_ch    <= '0;
      debounced    <= '0;
    end else begin
      state        <= state_nxt;
      sync1        <= noisy;
      sync2        <= sync1;
      cnt          <= cnt_nxt;
      ptr          <= ptr_nxt;
      active_ch    <= active_ch_nxt;
      busy         <= busy_nxt;
      change_pulse <= pulse_nxt;
      change_ch    <= change_ch_nxt;
      debounced    <= debounced_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb/tb_debounce_scheduler.sv - directed bench for debounce_scheduler
// HOLD_CYCLES=4, N_CH=4.
module tb_debounce_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] noisy;
  logic       enable;
  logic [3:0] debounced;
  logic       change_pulse;
  logic [1:0] change_ch;
  logic       busy;
  logic [1:0] active_ch;

  int checks = 0;
  int errors = 0;

  debounce_scheduler #(.N_CH(4), .CH_W(2), .CNT_W(20), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .noisy(noisy), .enable(enable),
    .debounced(debounced), .change_pulse(change_pulse), .change_ch(change_ch),
    .busy(busy), .active_ch(active_ch)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; noisy = 4'h0;
    step(); step();
    checks++; if (debounced !== 4'h0) begin errors++; $display("FAIL reset_debounced got %h exp 0", debounced); end
    checks++; if (change_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", change_pulse); end
    checks++; if (change_ch !== 2'd0) begin errors++; $display("FAIL reset_change_ch got %0d exp 0", change_ch); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL reset_active_ch got %0d exp 0", active_ch); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    noisy = 4'h2;
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++; if (change_pulse !== (k == 7)) begin errors++; $display("FAIL single_pulse k=%0d got %b exp %b", k, change_pulse, k == 7); end
      checks++; if (busy !== (k >= 3 && k <= 6)) begin errors++; $display("FAIL single_busy k=%0d got %b", k, busy); end
      checks++; if (debounced !== ((k >= 7) ? 4'h2 : 4'h0)) begin errors++; $display("FAIL single_debounced k=%0d got %h", k, debounced); end
      if (k == 3) begin
        checks++; if (active_ch !== 2'd1) begin errors++; $display("FAIL single_active k=%0d got %0d exp 1", k, active_ch); end
      end
      if (k == 7) begin
        checks++; if (change_ch !== 2'd1) begin errors++; $display("FAIL single_change_ch got %0d exp 1", change_ch); end
      end
    end
  endtask

  task automatic test_glitch();
    noisy = 4'h6;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 2) noisy = 4'h2;
      checks++; if (change_pulse !== 1'b0) begin errors++; $display("FAIL glitch_pulse k=%0d got %b exp 0", k, change_pulse); end
      checks++; if (busy !== (k == 3 || k == 4)) begin errors++; $display("FAIL glitch_busy k=%0d got %b", k, busy); end
      checks++; if (debounced !== 4'h2) begin errors++; $display("FAIL glitch_debounced k=%0d got %h exp 2", k, debounced); end
    end
  endtask

  task automatic test_wrap();
    noisy = 4'hB;
    for (int k = 1; k <= 14; k++) begin
      step();
      checks++; if (change_pulse !== (k == 7 || k == 12)) begin errors++; $display("FAIL wrap_pulse k=%0d got %b", k, change_pulse); end
      checks++; if (busy !== ((k >= 3 && k <= 6) || (k >= 8 && k <= 11))) begin errors++; $display("FAIL wrap_busy k=%0d got %b", k, busy); end
      if (k == 3) begin
        checks++; if (active_ch !== 2'd3) begin errors++; $display("FAIL wrap_first_grant got %0d exp 3", active_ch); end
      end
      if (k == 8) begin
        checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL wrap_second_grant got %0d exp 0", active_ch); end
      end
      if (k == 7) begin
        checks++; if (change_ch !== 2'd3 || debounced !== 4'hA) begin errors++; $display("FAIL wrap_commit3 ch %0d deb %h exp 3 A", change_ch, debounced); end
      end
      if (k == 12) begin
        checks++; if (change_ch !== 2'd0 || debounced !== 4'hB) begin errors++; $display("FAIL wrap_commit0 ch %0d deb %h exp 0 B", change_ch, debounced); end
      end
    end
    // ptr should now be 1: with ch0 and ch3 requesting again, ch3 wins.
    noisy = 4'h2;
    for (int k = 1; k <= 3; k++) step();
    checks++; if (busy !== 1'b1 || active_ch !== 2'd3) begin errors++; $display("FAIL wrap_ptr busy %b active %0d exp 1 3", busy, active_ch); end
  endtask

  task automatic test_simultaneous();
    reset = 1'b0; noisy = 4'h0;
    step();
    checks++; if (busy !== 1'b0 || change_pulse !== 1'b0 || debounced !== 4'h0) begin errors++; $display("FAIL simul_reset busy %b pulse %b deb %h", busy, change_pulse, debounced); end
    reset = 1'b1;
    step();
    noisy = 4'h5;
    for (int k = 1; k <= 13; k++) begin
      step();
      checks++; if (change_pulse !== (k == 7 || k == 12)) begin errors++; $display("FAIL simul_pulse k=%0d got %b", k, change_pulse); end
      if (k == 7) begin
        checks++; if (change_ch !== 2'd0 || debounced !== 4'h1) begin errors++; $display("FAIL simul_commit0 ch %0d deb %h exp 0 1", change_ch, debounced); end
      end
      if (k == 12) begin
        checks++; if (change_ch !== 2'd2 || debounced !== 4'h5) begin errors++; $display("FAIL simul_commit2 ch %0d deb %h exp 2 5", change_ch, debounced); end
      end
    end
  endtask

  task automatic test_enable();
    noisy = 4'h7;
    for (int k = 1; k <= 5; k++) step();
    checks++; if (busy !== 1'b1 || active_ch !== 2'd1) begin errors++; $display("FAIL enable_grant busy %b active %0d exp 1 1", busy, active_ch); end
    enable = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enable_drop_busy got %b exp 0", busy); end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (busy !== 1'b0 || change_pulse !== 1'b0 || debounced !== 4'h5) begin errors++; $display("FAIL enable_hold k=%0d busy %b pulse %b deb %h", k, busy, change_pulse, debounced); end
    end
    enable = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      step();
      checks++; if (busy !== (j <= 4)) begin errors++; $display("FAIL enable_recount_busy j=%0d got %b", j, busy); end
      checks++; if (change_pulse !== (j == 5)) begin errors++; $display("FAIL enable_recount_pulse j=%0d got %b", j, change_pulse); end
    end
    checks++; if (debounced !== 4'h7 || change_ch !== 2'd1) begin errors++; $display("FAIL enable_commit deb %h ch %0d exp 7 1", debounced, change_ch); end
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] exp_deb;
    int n;
    noisy = 4'hF;
    for (int k = 1; k <= 6; k++) step();
    checks++; if (busy !== 1'b1 || active_ch !== 2'd3) begin errors++; $display("FAIL midrst_grant busy %b active %0d exp 1 3", busy, active_ch); end
    reset = 1'b0;
    step();
    checks++; if (debounced !== 4'h0 || change_pulse !== 1'b0 || change_ch !== 2'd0 || busy !== 1'b0 || active_ch !== 2'd0) begin
      errors++; $display("FAIL midrst_clear deb %h pulse %b ch %0d busy %b active %0d", debounced, change_pulse, change_ch, busy, active_ch);
    end
    reset = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      step();
      n = (k >= 22) ? 4 : (k >= 17) ? 3 : (k >= 12) ? 2 : (k >= 7) ? 1 : 0;
      exp_deb = 4'((1 << n) - 1);
      checks++; if (debounced !== exp_deb) begin errors++; $display("FAIL midrst_debounced k=%0d got %h exp %h", k, debounced, exp_deb); end
      checks++; if (change_pulse !== (k == 7 || k == 12 || k == 17 || k == 22)) begin errors++; $display("FAIL midrst_pulse k=%0d got %b", k, change_pulse); end
      if (k == 7 || k == 12 || k == 17 || k == 22) begin
        checks++; if (change_ch !== 2'((k - 7) / 5)) begin errors++; $display("FAIL midrst_order k=%0d got %0d exp %0d", k, change_ch, (k - 7) / 5); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_wrap();
    test_simultaneous();
    test_enable();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
